regfile_write_arbiter: RTL and testbench

// - Shares the single write port of the 4x8 Registers file among NUM_REQ write-back sources.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_write_arbiter_if.sv | 26 ++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/regfile_write_arbiter.sv | 65 ++++++
 tb/tb_regfile_write_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and types used by the write arbiter,
// the register file and the decode stage.
package regfile_pkg;

   localparam int DATA_W     = 8;
   localparam int REG_ADDR_W = 2;
   localparam int NUM_REGS   = 2 ** REG_ADDR_W;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0]     reg_data_t;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t r);
      return NUM_REGS'(1) << r;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Write-back request bus between the requesters and the arbiter, plus the
// registered write port and hazard mask the arbiter drives.
interface regfile_write_arbiter_if #(parameter int NUM_REQ = 3);
   import regfile_pkg::*;

   logic                         hold;
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*REG_ADDR_W-1:0] req_reg;
   logic [NUM_REQ*DATA_W-1:0]    req_data;
   logic [NUM_REQ-1:0]           req_ready;
   logic                         write;
   reg_idx_t                     write_reg;
   reg_data_t                    write_data;
   logic [NUM_REGS-1:0]          pending_mask;

   modport master (
      output hold, req_valid, req_reg, req_data,
      input  req_ready, write, write_reg, write_data, pending_mask
   );

   modport slave (
      input  hold, req_valid, req_reg, req_data,
      output req_ready, write, write_reg, write_data, pending_mask
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; the scan starts at rr_ptr, which
// advances to one past the winner only when a grant is actually issued.
module rr_arbiter #(
   parameter  int NUM_REQ = 3,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_b,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid
);

   logic [IDX_W-1:0] rr_ptr_q;
   logic [IDX_W-1:0] rr_ptr_d;
   int               idx;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      idx         = 0;
      if (en) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_valid && req[idx]) begin
               grant[idx]  = 1'b1;
               grant_idx   = IDX_W'(idx);
               grant_valid = 1'b1;
            end
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_valid) begin
         rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) rr_ptr_q <= '0;
      else        rr_ptr_q <= rr_ptr_d;
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port among NUM_REQ write-back sources
// through a registered output stage, and publishes the in-flight target mask.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   regfile_write_arbiter_if.slave  bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               grant_valid;
   logic               arb_en;

   logic      write_q,      write_d;
   reg_idx_t  write_reg_q,  write_reg_d;
   reg_data_t write_data_q, write_data_d;

   // Gating on reset keeps req_ready low while reset is asserted, not just after.
   assign arb_en = reset && !bus.hold;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .clk         (clk),
      .rst_b       (reset),
      .req         (bus.req_valid),
      .en          (arb_en),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always_comb begin
      write_d      = grant_valid;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      if (grant_valid) begin
         write_reg_d  = bus.req_reg[int'(grant_idx)*REG_ADDR_W +: REG_ADDR_W];
         write_data_d = bus.req_data[int'(grant_idx)*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         write_q      <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         write_q      <= write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   assign bus.req_ready    = grant;
   assign bus.write        = write_q;
   assign bus.write_reg    = write_reg_q;
   assign bus.write_data   = write_data_q;
   assign bus.pending_mask = write_q ? reg_onehot(write_reg_q) : '0;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter with a behavioural register file behind it;
// accepted writes are queued and matched against the output stage.
module tb_regfile_write_arbiter;
   import regfile_pkg::*;

   localparam int NREQ = 3;

   logic clk;
   logic reset;

   regfile_write_arbiter_if #(.NUM_REQ(NREQ)) bus ();

   regfile_write_arbiter #(.NUM_REQ(NREQ)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   reg_data_t rf [NUM_REGS];

   always @(posedge clk) begin
      if (bus.write) rf[bus.write_reg] <= bus.write_data;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   int        m_ptr;
   logic      m_wr;
   reg_idx_t  m_wreg;
   reg_data_t m_wdata;
   logic [REG_ADDR_W+DATA_W-1:0] sb_q [$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic v, input reg_idx_t r, input reg_data_t d);
      bus.req_valid[i]                        = v;
      bus.req_reg[i*REG_ADDR_W +: REG_ADDR_W] = r;
      bus.req_data[i*DATA_W +: DATA_W]        = d;
   endtask

   function automatic int pred_grant();
      int idx;
      if (!reset || bus.hold) return -1;
      for (int k = 0; k < NREQ; k++) begin
         idx = (m_ptr + k) % NREQ;
         if (bus.req_valid[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr   = 0;
      m_wr    = 1'b0;
      m_wreg  = '0;
      m_wdata = '0;
      sb_q.delete();
   endtask

   task automatic check_outputs();
      logic [REG_ADDR_W+DATA_W-1:0] e;
      logic [NUM_REGS-1:0]          pm;
      pm = '0;
      if (m_wr) pm[m_wreg] = 1'b1;
      chk("write",        32'(bus.write),        32'(m_wr));
      chk("write_reg",    32'(bus.write_reg),    32'(m_wreg));
      chk("write_data",   32'(bus.write_data),   32'(m_wdata));
      chk("pending_mask", 32'(bus.pending_mask), 32'(pm));
      if (bus.write) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_write", 32'(1), 32'(0));
         end else begin
            e = sb_q.pop_front();
            chk("sb_reg",  32'(bus.write_reg),  32'(e[DATA_W +: REG_ADDR_W]));
            chk("sb_data", 32'(bus.write_data), 32'(e[DATA_W-1:0]));
         end
      end
   endtask

   // Called just after a falling edge with inputs already set; returns at the next falling edge.
   task automatic cycle();
      int                g;
      logic [NREQ-1:0]   exp_rdy;
      reg_idx_t          r;
      reg_data_t         d;
      #1;
      g       = pred_grant();
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      @(posedge clk);
      if (g >= 0) begin
         r = bus.req_reg[g*REG_ADDR_W +: REG_ADDR_W];
         d = bus.req_data[g*DATA_W +: DATA_W];
         sb_q.push_back({r, d});
         m_wr    = 1'b1;
         m_wreg  = r;
         m_wdata = d;
         m_ptr   = (g + 1) % NREQ;
      end else begin
         m_wr = 1'b0;
      end
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] = '0;
      reset         = 1'b0;
      bus.hold      = 1'b0;
      bus.req_valid = '0;
      bus.req_reg   = '0;
      bus.req_data  = '0;
      model_reset();

      // reset with every requester asking
      set_req(0, 1'b1, 2'd0, 8'h10);
      set_req(1, 1'b1, 2'd1, 8'h20);
      set_req(2, 1'b1, 2'd2, 8'h30);
      repeat (2) @(negedge clk);
      chk("rst_ready",   32'(bus.req_ready),    32'(3'b000));
      chk("rst_write",   32'(bus.write),        32'(0));
      chk("rst_wreg",    32'(bus.write_reg),    32'(0));
      chk("rst_wdata",   32'(bus.write_data),   32'(0));
      chk("rst_pending", 32'(bus.pending_mask), 32'(4'b0000));
      reset         = 1'b1;
      bus.req_valid = '0;

      // single request from requester 1
      set_req(1, 1'b1, 2'd2, 8'h55);
      #1 chk("single_ready", 32'(bus.req_ready), 32'(3'b010));
      cycle();
      chk("single_write",   32'(bus.write),        32'(1));
      chk("single_wreg",    32'(bus.write_reg),    32'(2));
      chk("single_wdata",   32'(bus.write_data),   32'(8'h55));
      chk("single_pending", 32'(bus.pending_mask), 32'(4'b0100));
      bus.req_valid = '0;
      cycle();
      chk("single_commit", 32'(rf[2]), 32'(8'h55));

      // requester 2 alone brings rr_ptr back to 0
      set_req(2, 1'b1, 2'd0, 8'h11);
      cycle();
      bus.req_valid = '0;
      cycle();

      // round robin with everyone valid
      set_req(0, 1'b1, 2'd0, 8'hA0);
      set_req(1, 1'b1, 2'd1, 8'hA1);
      set_req(2, 1'b1, 2'd2, 8'hA2);
      for (int i = 0; i < 6; i++) begin
         #1 chk("rr_ready", 32'(bus.req_ready), 32'(3'b001 << (i % 3)));
         cycle();
         chk("rr_write", 32'(bus.write), 32'(1));
      end
      bus.req_valid = '0;
      cycle();

      // same-register conflict, later grant wins
      set_req(0, 1'b1, 2'd3, 8'hCC);
      set_req(2, 1'b1, 2'd3, 8'h33);
      cycle();
      bus.req_valid[0] = 1'b0;
      cycle();
      chk("conflict_first", 32'(rf[3]), 32'(8'hCC));
      bus.req_valid = '0;
      cycle();
      chk("conflict_final", 32'(rf[3]), 32'(8'h33));

      // hold freezes arbitration and keeps rr_ptr
      set_req(0, 1'b1, 2'd0, 8'h5A);
      cycle();
      bus.req_valid = '0;
      set_req(1, 1'b1, 2'd1, 8'hB1);
      set_req(2, 1'b1, 2'd2, 8'hB2);
      bus.hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("hold_ready", 32'(bus.req_ready), 32'(0));
         chk("hold_write", 32'(bus.write),     32'(0));
      end
      bus.hold = 1'b0;
      #1 chk("hold_resume", 32'(bus.req_ready), 32'(3'b010));
      cycle();
      bus.req_valid = '0;
      cycle();

      // reset while a write sits in the output stage
      chk("pre_rst_reg1", 32'(rf[1]), 32'(8'hB1));
      set_req(0, 1'b1, 2'd1, 8'h77);
      cycle();
      chk("mid_write_pre", 32'(bus.write), 32'(1));
      bus.req_valid = '0;
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_write",   32'(bus.write),        32'(0));
      chk("mid_rst_pending", 32'(bus.pending_mask), 32'(0));
      chk("mid_rst_ready",   32'(bus.req_ready),    32'(0));
      model_reset();
      set_req(0, 1'b1, 2'd0, 8'hE0);
      set_req(1, 1'b1, 2'd1, 8'hE1);
      set_req(2, 1'b1, 2'd2, 8'hE2);
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_nocommit", 32'(rf[1]), 32'(8'hB1));
      check_outputs();
      reset = 1'b1;
      #1 chk("rst_first_grant", 32'(bus.req_ready), 32'(3'b001));
      cycle();
      bus.req_valid = '0;
      cycle();
      chk("sb_drained", 32'(sb_q.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
